// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default bit period
// (100 MHz system clock, 115200 baud), also intended for the transmitter.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 868;

  typedef enum logic [2:0] {
    HUNT  = 3'd0,
    IDLE  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO with occupancy count. A push while full is accepted
// only when a pop happens in the same cycle. The head reads as zero when empty
// so the consumer-side data bus is quiet out of reset.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CNTW-1:0]  count;
  logic             wr_en;
  logic             rd_en;

  assign empty     = (count == '0);
  assign full      = (count == CNTW'(DEPTH));
  assign rd_en     = pop && !empty;
  assign wr_en     = push && (!full || rd_en);
  assign head_data = empty ? '0 : mem[rd_ptr];

  // Storage array; contents are only meaningful under the occupancy count.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver: synchronizes ser_rx, deframes LSB-first characters using
// mid-bit sampling and hands bytes to the bus side through a small FIFO.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ser_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int            HALF      = CLKS_PER_BIT / 2;
  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  logic            sync_p0;
  logic            rxs;
  rx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            stop_ok;
  logic            stop_bad;
  logic            pop;
  logic            fifo_empty;
  logic            fifo_full;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      sync_p0 <= ser_rx;
      rxs     <= sync_p0;
    end
  end

  // Deframer control registers: state, bit-period counter, bit index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HUNT;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Shift register holds payload only, so it is not reset.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  // Next-state logic: start is validated at mid-bit, data and stop are then
  // sampled one full bit period apart so every sample lands mid-bit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    case (state_q)
      HUNT: begin
        cnt_d = '0;
        if (rxs) state_d = IDLE;
      end
      IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          idx_d = '0;
          state_d = rxs ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shreg_d = {rxs, shreg_q[7:1]};
          if (idx_q == 3'd7) state_d = STOP;
          else idx_d = idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rxs) begin
            stop_ok = 1'b1;
            state_d = IDLE;
          end else begin
            // Bad stop or break: wait for the line to go high before rearming.
            stop_bad = 1'b1;
            state_d  = HUNT;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = HUNT;
        cnt_d   = '0;
      end
    endcase
  end

  // Error pulses, registered so each lasts exactly one cycle after the stop sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= stop_ok && fifo_full && !pop;
    end
  end

  assign pop      = rx_valid && rx_ready;
  assign rx_valid = !fifo_empty;

  uart_rx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (stop_ok),
    .push_data (shreg_q),
    .pop       (pop),
    .head_data (rx_data),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clocks per bit with a 4-entry FIFO.
module tb_uart_rx;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       ser_rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  int vectors = 0;
  int miscompares = 0;
  int cyc, first_valid, valid_cycles, fe_cnt, ov_cnt;
  logic [7:0] first_data;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .ser_rx    (ser_rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
    if (rx_valid) begin
      if (first_valid < 0) begin
        first_valid = cyc;
        first_data  = rx_data;
      end
      valid_cycles++;
      if (rx_ready) got_q.push_back(rx_data);
    end
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    cyc = 0; first_valid = -1; valid_cycles = 0; fe_cnt = 0; ov_cnt = 0;
    first_data = 8'h00;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic idle(input int n);
    ser_rx = 1'b1;
    repeat (n) step();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int rdy_at, input int rst_at);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int c = 0; c < 10 * CPB; c++) begin
      ser_rx = bits[c / CPB];
      if (c == rdy_at) rx_ready = 1'b1;
      else if (rdy_at >= 0 && c == rdy_at + 1) rx_ready = 1'b0;
      if (c == rst_at) reset = 1'b1;
      else if (rst_at >= 0 && c == rst_at + 2) reset = 1'b0;
      step();
    end
  endtask

  task automatic drain_check(input string name);
    logic [7:0] e, g;
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL %s_count: got %0d bytes, want %0d", name, got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL %s_data: got %h, want %h", name, g, e);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; ser_rx = 1'b1; rx_ready = 1'b0;
    clear_mon();
    repeat (3) step();
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b, want 0", rx_valid); end
    vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL rst_data: got %h, want 00", rx_data); end
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL rst_frame_err: got %b, want 0", frame_err); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL rst_overrun: got %b, want 0", overrun); end
    reset = 1'b0;
    idle(10);
    vectors++; if (valid_cycles !== 0) begin miscompares++; $display("FAIL rst_idle_valid: got %0d, want 0", valid_cycles); end
  endtask

  task automatic test_byte_a5();
    rx_ready = 1'b1;
    clear_mon();
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, -1, -1);
    idle(20);
    // pin->rxs 2 cycles, rxs->IDLE edge 1, HALF+9*CPB = 152 to stop sample
    vectors++; if (first_valid !== 155) begin miscompares++; $display("FAIL a5_latency: got %0d, want 155", first_valid); end
    vectors++; if (first_data !== 8'hA5) begin miscompares++; $display("FAIL a5_data: got %h, want a5", first_data); end
    vectors++; if (valid_cycles !== 1) begin miscompares++; $display("FAIL a5_valid_width: got %0d, want 1", valid_cycles); end
    vectors++; if (fe_cnt !== 0 || ov_cnt !== 0) begin miscompares++; $display("FAIL a5_errors: got fe=%0d ov=%0d, want 0 0", fe_cnt, ov_cnt); end
    drain_check("a5");
  endtask

  task automatic test_glitch();
    rx_ready = 1'b1;
    clear_mon();
    ser_rx = 1'b0;
    repeat (4) step();
    idle(40);
    vectors++; if (valid_cycles !== 0) begin miscompares++; $display("FAIL glitch_valid: got %0d, want 0", valid_cycles); end
    vectors++; if (fe_cnt !== 0 || ov_cnt !== 0) begin miscompares++; $display("FAIL glitch_errors: got fe=%0d ov=%0d, want 0 0", fe_cnt, ov_cnt); end
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b1, -1, -1);
    idle(20);
    drain_check("glitch_after");
  endtask

  task automatic test_frame_err();
    rx_ready = 1'b1;
    clear_mon();
    send_frame(8'h5A, 1'b0, -1, -1);
    ser_rx = 1'b0;
    repeat (40) step();
    idle(20);
    vectors++; if (fe_cnt !== 1) begin miscompares++; $display("FAIL ferr_pulse: got %0d cycles, want 1", fe_cnt); end
    vectors++; if (valid_cycles !== 0) begin miscompares++; $display("FAIL ferr_push: got %0d valid cycles, want 0", valid_cycles); end
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, -1, -1);
    idle(20);
    vectors++; if (fe_cnt !== 1 || ov_cnt !== 0) begin miscompares++; $display("FAIL ferr_after: got fe=%0d ov=%0d, want 1 0", fe_cnt, ov_cnt); end
    drain_check("ferr_3c");
  endtask

  task automatic test_overrun();
    rx_ready = 1'b0;
    clear_mon();
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1, -1, -1);
    end
    idle(20);
    vectors++; if (ov_cnt !== 1) begin miscompares++; $display("FAIL ovr_pulse: got %0d cycles, want 1", ov_cnt); end
    vectors++; if (rx_valid !== 1'b1) begin miscompares++; $display("FAIL ovr_full_valid: got %b, want 1", rx_valid); end
    rx_ready = 1'b1;
    idle(10);
    rx_ready = 1'b0;
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL ovr_empty: got %b, want 0", rx_valid); end
    drain_check("ovr");
  endtask

  task automatic test_push_pop_full();
    rx_ready = 1'b0;
    clear_mon();
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back(8'(i));
      // ready high only for the cycle that ends at the 5th stop-bit sample
      send_frame(8'(i), 1'b1, (i == 5) ? 154 : -1, -1);
    end
    idle(20);
    vectors++; if (ov_cnt !== 0) begin miscompares++; $display("FAIL pp_overrun: got %0d cycles, want 0", ov_cnt); end
    rx_ready = 1'b1;
    idle(10);
    rx_ready = 1'b0;
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL pp_empty: got %b, want 0", rx_valid); end
    drain_check("pp");
  endtask

  task automatic test_reset_mid();
    rx_ready = 1'b0;
    clear_mon();
    send_frame(8'h11, 1'b1, -1, -1);
    idle(10);
    vectors++; if (rx_valid !== 1'b1) begin miscompares++; $display("FAIL rmid_preload: got %b, want 1", rx_valid); end
    // 0xF7 has bit 3 low; reset lands mid data bit 3
    send_frame(8'hF7, 1'b1, -1, 4 * CPB + 8);
    idle(20);
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_valid: got %b, want 0", rx_valid); end
    vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL rmid_data: got %h, want 00", rx_data); end
    vectors++; if (fe_cnt !== 0 || ov_cnt !== 0) begin miscompares++; $display("FAIL rmid_errors: got fe=%0d ov=%0d, want 0 0", fe_cnt, ov_cnt); end
    rx_ready = 1'b1;
    got_q.delete();
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, -1, -1);
    idle(20);
    drain_check("rmid_c3");
  endtask

  initial begin
    test_reset();
    test_byte_a5();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_push_pop_full();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
